// File: rtl/seq_det_scheduler_if.sv
// Handshake and detector-side bundle for seq_det_scheduler.
// slave  = the scheduler itself; master = host, result consumer and detector.
// Optional first-match fields are present only when FIRST_POS_EN is defined.
interface seq_det_scheduler_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 6
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              det_rst;
  logic              det_in;
  logic              det_out;
  logic [CNT_W-1:0]  match_cnt;
  logic              result_valid;
  logic              result_ready;
  logic              busy;
`ifdef FIRST_POS_EN
  logic              first_hit;
  logic [CNT_W-1:0]  first_pos;

  modport master (
    output word_in, word_valid, det_out, result_ready,
    input  word_ready, det_rst, det_in, match_cnt, result_valid, busy,
           first_hit, first_pos
  );
  modport slave (
    input  word_in, word_valid, det_out, result_ready,
    output word_ready, det_rst, det_in, match_cnt, result_valid, busy,
           first_hit, first_pos
  );
`else
  modport master (
    output word_in, word_valid, det_out, result_ready,
    input  word_ready, det_rst, det_in, match_cnt, result_valid, busy
  );
  modport slave (
    input  word_in, word_valid, det_out, result_ready,
    output word_ready, det_rst, det_in, match_cnt, result_valid, busy
  );
`endif
endinterface

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: accepts a word, resets a serial pattern detector, shifts
// the word into it MSB-first and counts the detector's match pulses that
// belong to the word's own bits. The count is returned over a valid/ready
// result handshake.
// Optional feature macro: FIRST_POS_EN adds first_hit / first_pos, which
// report the bit index whose detector response was the first counted match.
module seq_det_scheduler #(
  parameter int WORD_W     = 32,
  parameter int CNT_W      = 6,
  parameter int DETECT_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  seq_det_scheduler_if.slave  bus
);

  // Index register also counts DRAIN cycles, so it needs at least 2 bits.
  localparam int IDX_W = ($clog2(WORD_W) > 2) ? $clog2(WORD_W) : 2;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] LAST_DRAIN = IDX_W'((DETECT_LAT > 0) ? DETECT_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_det_in;
  logic              r_word_ready;
  logic              r_result_valid;
  logic              r_busy;
  logic              r_clear;

  logic w_accept;
  logic w_shift_win;
  logic w_count;

  assign w_accept = (r_state == S_IDLE) && bus.word_valid;

  // The first DETECT_LAT SHIFT cycles still show responses to pre-word input.
  generate
    if (DETECT_LAT == 0) begin : g_win_all
      assign w_shift_win = 1'b1;
    end else begin : g_win_lat
      assign w_shift_win = (r_idx >= IDX_W'(DETECT_LAT));
    end
  endgenerate

  assign w_count = bus.det_out &&
                   (((r_state == S_SHIFT) && w_shift_win) || (r_state == S_DRAIN));

  // Controller FSM: state, shift register, bit index and registered handshake outputs.
  // NOTE: every sequential assignment uses <= so all registers update from
  // pre-edge values; a blocking = here would let later lines see new values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_shift        <= '0;
      r_idx          <= '0;
      r_det_in       <= 1'b0;
      r_word_ready   <= 1'b1;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_clear        <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.word_valid) begin
            r_shift      <= bus.word_in;
            r_state      <= S_CLEAR;
            r_word_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_clear      <= 1'b1;
          end
        end
        S_CLEAR: begin
          // Present the MSB for SHIFT index 0 right away.
          r_clear  <= 1'b0;
          r_idx    <= '0;
          r_det_in <= r_shift[WORD_W-1];
          r_shift  <= {r_shift[WORD_W-2:0], 1'b0};
          r_state  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_idx == LAST_IDX) begin
            r_det_in <= 1'b0;
            r_idx    <= '0;
            if (DETECT_LAT == 0) begin
              r_state        <= S_DONE;
              r_result_valid <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_idx    <= r_idx + IDX_W'(1);
            r_det_in <= r_shift[WORD_W-1];
            r_shift  <= {r_shift[WORD_W-2:0], 1'b0};
          end
        end
        S_DRAIN: begin
          if (r_idx == LAST_DRAIN) begin
            r_state        <= S_DONE;
            r_result_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (bus.result_ready) begin
            r_state        <= S_IDLE;
            r_result_valid <= 1'b0;
            r_word_ready   <= 1'b1;
            r_busy         <= 1'b0;
          end
        end
        // NOTE: the default arm recovers from unused encodings instead of
        // leaving the FSM stuck in an illegal state.
        default: begin
          r_state        <= S_IDLE;
          r_word_ready   <= 1'b1;
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_clear        <= 1'b0;
          r_det_in       <= 1'b0;
        end
      endcase
    end
  end

  // Saturating match counter; zeroed on acceptance so it reads 0 from CLEAR on.
  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_cnt <= '0;
    end else if (w_count && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef FIRST_POS_EN
  logic             r_first_hit;
  logic [CNT_W-1:0] r_first_pos;
  logic [CNT_W-1:0] w_resp_pos;

  // Bit index whose response is on det_out this cycle.
  assign w_resp_pos = (r_state == S_DRAIN)
                    ? CNT_W'(WORD_W - DETECT_LAT + int'(r_idx))
                    : CNT_W'(int'(r_idx) - DETECT_LAT);

  // Capture the position of the first counted match.
  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_first_hit <= 1'b0;
      r_first_pos <= '0;
    end else if (w_count && !r_first_hit) begin
      r_first_hit <= 1'b1;
      r_first_pos <= w_resp_pos;
    end
  end

  assign bus.first_hit = r_first_hit;
  assign bus.first_pos = r_first_pos;
`endif

  // Detector reset follows the controller reset combinationally.
  assign bus.det_rst      = reset | r_clear;
  assign bus.det_in       = r_det_in;
  assign bus.word_ready   = r_word_ready;
  assign bus.result_valid = r_result_valid;
  assign bus.busy         = r_busy;
  assign bus.match_cnt    = r_cnt;

endmodule
